nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a wide add of two 4*NIBBLES-bit operands one nibble per clock, through a single internal 4-bit add slice (a + b + carry-in).
- Holds a carry register between nibbles.
- Used where area matters more than latency.
- Sits between a requester (valid/ready command side) and a consumer (valid/ready result side).

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start_valid  input  1  requester presents operands
start_ready  output  1  block can accept a command (high only in IDLE)
op_a  input  W  operand A, sampled on accept
op_b  input  W  operand B, sampled on accept
cin  input  1  carry into nibble 0, sampled on accept
res_valid  output  1  result available (high only in DONE)
res_ready  input  1  consumer accepts result
sum  output  W  result, registered
cout  output  1  carry out of the top nibble, registered
busy  output  1  high in RUN or DONE

Behaviour:
Reset values:
- state=IDLE, start_ready=1, res_valid=0, busy=0, sum=0, cout=0.
- Internal carry=0, nibble index=0.

States:
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready at edge k: latch op_a, op_b, cin; carry<=cin; idx<=0; go to RUN.
  - sum and cout keep their previous values until overwritten.
- RUN:
  - Each cycle the slice computes a_nib[idx] + b_nib[idx] + carry.
  - Write the 4-bit result into sum[4*idx+3:4*idx].
  - carry<=slice carry-out; idx<=idx+1.
  - Nibble 0 is processed at edge k+1 and the last nibble at edge k+NIBBLES.
  - On the last nibble, cout<=slice carry-out and the state goes to DONE.
- DONE:
  - res_valid=1; sum and cout are stable and held.
  - On res_valid&res_ready: go to IDLE; res_valid deasserts and start_ready reasserts at the next cycle.

Latency and throughput:
- res_valid first high in the cycle after edge k+NIBBLES, i.e. NIBBLES+1 cycles after the accept edge.
- Minimum command-to-command spacing: NIBBLES+2 cycles.
- No same-cycle result-retire and command-accept.

Boundary conditions:
- start_valid outside IDLE is ignored: start_ready=0 and no operand sampling.
- Operand inputs may change freely after accept; only the latched copies are used.
- Nibble index wraps/clears to 0 on every accept; it never exceeds NIBBLES-1.
- NIBBLES=1: RUN lasts exactly one cycle.
- A carry out of nibble i always feeds nibble i+1. The full-width result is (op_a + op_b + cin) mod 2^W, with cout as bit W.
- res_ready held low: stay in DONE indefinitely with outputs stable.
- rst in any state, including mid-RUN or DONE, takes priority over all handshakes. It aborts the operation and forces all reset values at the next edge; the partial sum is discarded (sum=0).
- res_ready asserted outside DONE has no effect.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds an input port sub (1 bit), sampled on accept alongside the operands.
  - When sub=1: each B nibble is bit-inverted before the slice, the initial carry is forced to 1 (cin ignored), and the result is op_a - op_b mod 2^W.
  - cout=1 means no borrow (op_a >= op_b unsigned).
  - sub=0 behaves exactly like add mode.
- Undefined: no sub port; add only.
- Timing is identical in both builds.

Test Plan (NIBBLES=4):
- Plain add: op_a=0x1234, op_b=0x4321, cin=0 -> res_valid 5 cycles after accept, sum=0x5555, cout=0.
- Full ripple: op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all 4 nibbles.
- Carry-in only, then backpressure:
  - Inputs: op_a=0x0000, op_b=0x0000, cin=1, with res_ready low for 3 cycles.
  - Required: sum=0x0001, cout=0 held stable.
  - start_valid pulsed during RUN/DONE is not accepted; start_ready returns high the cycle after the res_ready handshake.
- Reset mid-operation: accept 0xABCD+0x1111, assert rst on the 2nd RUN cycle -> next cycle state IDLE, sum=0, cout=0, res_valid=0, start_ready=1. A new command 0x0002+0x0003 then gives sum=0x0005.
- Back-to-back: two commands with start_valid held high -> second accepted exactly NIBBLES+2 cycles after the first; both results correct.
- SERIAL_ADD_SUB_EN: sub=1, op_a=0x0005, op_b=0x0007 -> sum=0xFFFE, cout=0. Then sub=1, op_a=0x0009, op_b=0x0004 -> sum=0x0005, cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial wide adder sequencer (optional SERIAL_ADD_SUB_EN adds subtract mode)
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                 sub,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic           carry_q;
    logic           cout_q;
    logic [IW-1:0]  idx_q;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [4:0]     slice;
    logic           last;
    logic           accept;
    logic [W-1:0]   b_in;
    logic           carry_in;

    // Subtract is a + ~b + 1, so B is stored pre-inverted and the seed carry forced high.
`ifdef SERIAL_ADD_SUB_EN
    assign b_in     = sub ? ~op_b : op_b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = op_b;
    assign carry_in = cin;
`endif

    // The single shared 4-bit slice works on the nibble selected by idx_q.
    assign a_nib  = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib  = b_q[{idx_q, 2'b00} +: 4];
    assign slice  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    assign last   = (idx_q == IW'(NIBBLES - 1));
    assign accept = start_valid && (state == IDLE);

    assign sum  = sum_q;
    assign cout = cout_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, carry chain and nibble-by-nibble result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= b_in;
            carry_q <= carry_in;
            idx_q   <= '0;
        end else if (state == RUN) begin
            sum_q[{idx_q, 2'b00} +: 4] <= slice[3:0];
            carry_q                    <= slice[4];
            if (last) begin
                cout_q <= slice[4];
                idx_q  <= '0;
            end else begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int bad   = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a(op_a),
        .op_b(op_b),
        .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .res_valid(res_valid),
        .res_ready(res_ready),
        .sum(sum),
        .cout(cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] es;
        logic         ec;
        int           hold;
        bit           poke;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Whole-word arithmetic reference: add, or two's-complement subtract.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (HAS_SUB && s) r = {1'b0, a} - {1'b0, b} + (W+1)'(1 << W);
        else              r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    // One full command: accept, latency, optional backpressure/pokes, retire.
    task automatic cmd(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic [W-1:0] es, input logic ec,
                       input int hold, input bit poke, input bit eager);
        int n;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            check({name, "_accept_timeout"}, 32'(start_ready), 32'd1);
            start_valid = 1'b0;
            return;
        end
        @(negedge clk);
        start_valid = poke;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        res_ready = eager;
        check({name, "_run_busy"}, 32'(busy), 32'd1);
        check({name, "_run_not_ready"}, 32'(start_ready), 32'd0);
        n = 1;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(NIBBLES + 1));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        if (!eager) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, "_hold_valid"}, 32'(res_valid), 32'd1);
                check({name, "_hold_sum"}, 32'({cout, sum}), 32'({ec, es}));
                if (poke) check({name, "_hold_not_ready"}, 32'(start_ready), 32'd0);
            end
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_retire_valid"}, 32'(res_valid), 32'd0);
        check({name, "_retire_ready"}, 32'(start_ready), 32'd1);
        check({name, "_idle_held"}, 32'({cout, sum}), 32'({ec, es}));
        if (poke) begin
            @(negedge clk);
            check({name, "_no_stale_accept"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [W:0]   m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           rt[$];
        int           nres;
        int           n;

        rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_start_ready", 32'(start_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);

        vecs.push_back('{"plain_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0});
        vecs.push_back('{"full_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0});
        vecs.push_back('{"cin_backpressure", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 3, 1'b1});
        vecs.push_back('{"carry_mid", 16'h0F80, 16'h0080, 1'b0, 1'b0, 16'h1000, 1'b0, 1, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{"sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0});
        vecs.push_back('{"sub_noborrow", 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 0, 1'b0});
`endif
        foreach (vecs[i])
            cmd(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s,
                vecs[i].es, vecs[i].ec, vecs[i].hold, vecs[i].poke, 1'b0);

        // Reset during the second RUN cycle discards the partial result.
        @(negedge clk);
        op_a = 16'hABCD; op_b = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_ready", 32'(start_ready), 32'd1);
        check("midrun_rst_valid", 32'(res_valid), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_sum", 32'({cout, sum}), 32'd0);
        cmd("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 0, 1'b0, 1'b0);

        // Back-to-back with start_valid held: accept spacing must be NIBBLES+2.
        @(negedge clk);
        op_a = 16'h0F0F; op_b = 16'h00F1; cin = 1'b0; sub = 1'b0;
        start_valid = 1'b1; res_ready = 1'b1;
        nres = 0;
        for (int t = 0; t < 20; t++) begin
            if (start_ready && start_valid) rt.push_back(t);
            if (res_valid) begin
                if (nres == 0) check("b2b_first", 32'({cout, sum}), 32'({1'b0, 16'h1000}));
                else           check("b2b_second", 32'({cout, sum}), 32'({1'b1, 16'h0001}));
                nres++;
            end
            @(negedge clk);
            if (t == 0) begin op_a = 16'h8000; op_b = 16'h8000; cin = 1'b1; end
            if (rt.size() >= 2) start_valid = 1'b0;
        end
        res_ready = 1'b0;
        start_valid = 1'b0;
        check("b2b_accepts", 32'(rt.size()), 32'd2);
        if (rt.size() >= 2) check("b2b_spacing", 32'(rt[1] - rt[0]), 32'(NIBBLES + 2));
        check("b2b_results", 32'(nres), 32'd2);

        // Randomized commands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            m = model(ra, rb, rc, rs);
            n = $urandom_range(0, 2);
            cmd("rand", ra, rb, rc, rs, m[W-1:0], m[W], n, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
